regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: read ports, write port, issue and flush.
interface regfile_scoreboard_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] readAdd1;
  logic [ADDR_W-1:0] readAdd2;
  logic [WIDTH-1:0]  out1;
  logic [WIDTH-1:0]  out2;
  logic              busy1;
  logic              busy2;
  logic              write;
  logic [ADDR_W-1:0] writeAdd;
  logic [WIDTH-1:0]  in;
  logic              issue;
  logic [ADDR_W-1:0] issueAdd;
  logic              flush;
  logic              issueStall;
  logic [ADDR_W:0]   busyCount;

  modport master (
    output readAdd1, readAdd2, write, writeAdd, in, issue, issueAdd, flush,
    input  out1, out2, busy1, busy2, issueStall, busyCount
  );

  modport slave (
    input  readAdd1, readAdd2, write, writeAdd, in, issue, issueAdd, flush,
    output out1, out2, busy1, busy2, issueStall, busyCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register pending-write scoreboard.
module regfile_scoreboard #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wr_en;
  logic             iss_acc;
  logic             stall;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             bsy1;
  logic             bsy2;

  // Write/issue qualification; a same-cycle write to the issue target resolves the hazard when bypassing.
  always_comb begin
    wr_en   = bus.write & ~(ZERO_REG && (bus.writeAdd == '0));
    stall   = bus.issue & busy[bus.issueAdd]
            & ~(BYPASS && bus.write && (bus.writeAdd == bus.issueAdd));
    iss_acc = bus.issue & ~stall & ~bus.flush
            & ~(ZERO_REG && (bus.issueAdd == '0));
  end

  // Next busy vector: write clears, accepted issue sets (new producer wins), flush clears all.
  always_comb begin
    busy_next = busy;
    cnt_next  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.write && (bus.writeAdd == ADDR_W'(i))) busy_next[i] = 1'b0;
      if (iss_acc && (bus.issueAdd == ADDR_W'(i)))   busy_next[i] = 1'b1;
    end
    if (bus.flush) busy_next = '0;
    if (ZERO_REG) busy_next[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + CNT_W'(busy_next[i]);
    end
  end

  // Data storage; reset clears every word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[bus.writeAdd] <= bus.in;
    end
  end

  // Scoreboard state and its population count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  // Read port 1 with optional write forwarding; forwarding is suppressed while in reset.
  always_comb begin
    rd1  = mem[bus.readAdd1];
    bsy1 = busy[bus.readAdd1];
    if (BYPASS && reset && bus.write && (bus.writeAdd == bus.readAdd1)) begin
      rd1  = bus.in;
      bsy1 = 1'b0;
    end
    if (ZERO_REG && (bus.readAdd1 == '0)) begin
      rd1  = '0;
      bsy1 = 1'b0;
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    rd2  = mem[bus.readAdd2];
    bsy2 = busy[bus.readAdd2];
    if (BYPASS && reset && bus.write && (bus.writeAdd == bus.readAdd2)) begin
      rd2  = bus.in;
      bsy2 = 1'b0;
    end
    if (ZERO_REG && (bus.readAdd2 == '0)) begin
      rd2  = '0;
      bsy2 = 1'b0;
    end
  end

  assign bus.out1       = rd1;
  assign bus.out2       = rd2;
  assign bus.busy1      = bsy1;
  assign bus.busy2      = bsy2;
  assign bus.issueStall = stall;
  assign bus.busyCount  = busy_cnt;

endmodule
